// File: rtl/mat_stream_loader_if.sv
// Word-stream handshake between the upstream source and the matrix loader.
// The master drives valid/data, the slave answers with ready.
interface mat_stream_loader_if #(
  parameter int DATA_LEN = 32
);
  logic                valid;
  logic                ready;
  logic [DATA_LEN-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mat_stream_loader.sv
// Packs a 32-bit word stream into rows, writes matrix A then matrix B into their
// memories, then kicks the matrix engine and waits for it to report done.
module mat_stream_loader #(
  parameter int DATA_LEN      = 32,
  parameter int N             = 8,
  parameter int M             = 8,
  parameter int ADDRESS_SIZE  = 4,
  parameter int A_ADDR_OFFSET = 8,
  parameter int B_ADDR_OFFSET = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_load_start,
  mat_stream_loader_if.slave       s_stream,
  output logic [ADDRESS_SIZE-1:0]  o_addr_A,
  output logic                     o_wr_en_A,
  output logic [DATA_LEN*N-1:0]    o_write_data_A,
  output logic [ADDRESS_SIZE-1:0]  o_addr_B,
  output logic                     o_wr_en_B,
  output logic [DATA_LEN*N-1:0]    o_write_data_B,
  output logic                     o_mem_own,
  output logic                     o_mat_start,
  input  logic                     i_mat_done,
  output logic                     o_done,
  output logic [2:0]               o_state
);

  localparam int COL_W    = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W    = (M > 1) ? $clog2(M) : 1;
  localparam int ROW_BITS = DATA_LEN * N;

  localparam logic [2:0] S_IDLE   = 3'd7;
  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [COL_W-1:0]        COL_LAST = COL_W'(N - 1);
  localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(M - 1);
  localparam logic [ADDRESS_SIZE-1:0] A_BASE   = ADDRESS_SIZE'(A_ADDR_OFFSET);
  localparam logic [ADDRESS_SIZE-1:0] B_BASE   = ADDRESS_SIZE'(B_ADDR_OFFSET);

  logic [2:0]              r_state;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [ROW_BITS-1:0]     r_buf;
  logic [ADDRESS_SIZE-1:0] r_addr_A;
  logic                    r_wr_en_A;
  logic [ROW_BITS-1:0]     r_write_data_A;
  logic [ADDRESS_SIZE-1:0] r_addr_B;
  logic                    r_wr_en_B;
  logic [ROW_BITS-1:0]     r_write_data_B;
  logic                    r_mem_own;
  logic                    r_mat_start;
  logic                    r_done;

  logic [2:0]              w_next_state;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_row_end;
  logic                    w_last_word;
  logic                    w_own_next;
  logic [ROW_BITS-1:0]     w_merged;
  logic [ROW_W-1:0]        w_row_inc;

  assign w_ready     = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_accept    = w_ready && s_stream.valid;
  assign w_row_end   = (r_col == COL_LAST);
  assign w_last_word = w_row_end && (r_row == ROW_LAST);
  assign w_row_inc   = (r_row == ROW_LAST) ? {ROW_W{1'b0}} : (r_row + ROW_W'(1));
  assign w_own_next  = (w_next_state == S_LOAD_A) || (w_next_state == S_LOAD_B) ||
                       (w_next_state == S_FLUSH);

  // Row buffer with the incoming word merged into its column slot (element 0 in the LSBs)
  always_comb begin
    w_merged = r_buf;
    if (w_accept) begin
      for (int c = 0; c < N; c++) begin
        if (r_col == COL_W'(c)) begin
          w_merged[DATA_LEN*c +: DATA_LEN] = s_stream.data;
        end else begin
          w_merged[DATA_LEN*c +: DATA_LEN] = r_buf[DATA_LEN*c +: DATA_LEN];
        end
      end
    end else begin
      w_merged = r_buf;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_load_start) w_next_state = S_LOAD_A; else w_next_state = S_IDLE;
      S_LOAD_A: if (w_accept && w_last_word) w_next_state = S_LOAD_B; else w_next_state = S_LOAD_A;
      S_LOAD_B: if (w_accept && w_last_word) w_next_state = S_FLUSH; else w_next_state = S_LOAD_B;
      S_FLUSH:  w_next_state = S_START;
      S_START:  w_next_state = S_WAIT;
      S_WAIT:   if (i_mat_done) w_next_state = S_DONE; else w_next_state = S_WAIT;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Column/row counters and pack buffer; the buffer is only ever overwritten, never cleared
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_col <= {COL_W{1'b0}};
      r_row <= {ROW_W{1'b0}};
      r_buf <= {ROW_BITS{1'b0}};
    end else if (r_state == S_IDLE) begin
      r_col <= {COL_W{1'b0}};
      r_row <= {ROW_W{1'b0}};
    end else if (w_accept) begin
      r_buf <= w_merged;
      if (w_row_end) begin
        r_col <= {COL_W{1'b0}};
        r_row <= w_row_inc;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Memory write ports: a completed row is registered and written the following cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr_A       <= {ADDRESS_SIZE{1'b0}};
      r_wr_en_A      <= 1'b0;
      r_write_data_A <= {ROW_BITS{1'b0}};
      r_addr_B       <= {ADDRESS_SIZE{1'b0}};
      r_wr_en_B      <= 1'b0;
      r_write_data_B <= {ROW_BITS{1'b0}};
    end else begin
      r_wr_en_A <= 1'b0;
      r_wr_en_B <= 1'b0;
      if (w_accept && w_row_end && (r_state == S_LOAD_A)) begin
        r_addr_A       <= A_BASE + ADDRESS_SIZE'(r_row);
        r_wr_en_A      <= 1'b1;
        r_write_data_A <= w_merged;
      end else if (w_accept && w_row_end && (r_state == S_LOAD_B)) begin
        r_addr_B       <= B_BASE + ADDRESS_SIZE'(r_row);
        r_wr_en_B      <= 1'b1;
        r_write_data_B <= w_merged;
      end else begin
        r_wr_en_A <= 1'b0;
        r_wr_en_B <= 1'b0;
      end
    end
  end

  // Engine handshake and ownership flags
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mem_own   <= 1'b0;
      r_mat_start <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_own   <= w_own_next;
      r_mat_start <= (r_state == S_FLUSH);
      r_done      <= (r_state == S_WAIT) && i_mat_done;
    end
  end

  assign s_stream.ready = w_ready;
  assign o_addr_A       = r_addr_A;
  assign o_wr_en_A      = r_wr_en_A;
  assign o_write_data_A = r_write_data_A;
  assign o_addr_B       = r_addr_B;
  assign o_wr_en_B      = r_wr_en_B;
  assign o_write_data_B = r_write_data_B;
  assign o_mem_own      = r_mem_own;
  assign o_mat_start    = r_mat_start;
  assign o_done         = r_done;
  assign o_state        = r_state;

endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed bench for mat_stream_loader: full loads, gapped stream, ignored
// requests, mid-load reset and stray engine-done pulses.
module tb_mat_stream_loader;

  logic         clk;
  logic         rstn;
  logic         load_start;
  logic         mat_done;
  logic [3:0]   addr_a, addr_b;
  logic         wr_a, wr_b;
  logic [255:0] wd_a, wd_b;
  logic         mem_own, mat_start, done;
  logic [2:0]   state;

  mat_stream_loader_if #(.DATA_LEN(32)) tb_if ();

  mat_stream_loader dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_load_start   (load_start),
    .s_stream       (tb_if),
    .o_addr_A       (addr_a),
    .o_wr_en_A      (wr_a),
    .o_write_data_A (wd_a),
    .o_addr_B       (addr_b),
    .o_wr_en_B      (wr_b),
    .o_write_data_B (wd_b),
    .o_mem_own      (mem_own),
    .o_mat_start    (mat_start),
    .i_mat_done     (mat_done),
    .o_done         (done),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic         clr;
  logic [255:0] mem_a [16];
  logic [255:0] mem_b [16];
  int           n_wr, n_both, n_bad, n_start;
  logic [2:0]   acc_mod;
  logic         prev_row_acc;

  // Memory models plus write-pulse bookkeeping
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 16; k++) begin
        mem_a[k] <= '0;
        mem_b[k] <= '0;
      end
      n_wr <= 0; n_both <= 0; n_bad <= 0; n_start <= 0;
      acc_mod <= 3'd0; prev_row_acc <= 1'b0;
    end else begin
      if (wr_a) mem_a[addr_a] <= wd_a;
      if (wr_b) mem_b[addr_b] <= wd_b;
      if (wr_a || wr_b) begin
        n_wr <= n_wr + 1;
        if (!prev_row_acc) n_bad <= n_bad + 1;
      end
      if (wr_a && wr_b) n_both <= n_both + 1;
      if (mat_start) n_start <= n_start + 1;
      if (!rstn) begin
        acc_mod <= 3'd0; prev_row_acc <= 1'b0;
      end else begin
        prev_row_acc <= tb_if.valid && tb_if.ready && (acc_mod == 3'd7);
        if (tb_if.valid && tb_if.ready) acc_mod <= acc_mod + 3'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_row(input int base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(base + k);
    return r;
  endfunction

  task automatic clear_model();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic kick();
    load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    check("start_state", state, 3'd0);
    check("start_ready", tb_if.ready, 1'b1);
    check("start_own", mem_own, 1'b1);
  endtask

  // Offer words first..first+count-1; returns at the negedge after the last acceptance
  task automatic send(input int first, input int count, input bit gap);
    int i = 0;
    int guard = 0;
    bit phase = 1'b0;
    while (i < count && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gap && phase) begin
        tb_if.valid = 1'b0;
        phase = 1'b0;
      end else begin
        tb_if.valid = 1'b1;
        tb_if.data  = 32'(first + i);
        if (tb_if.ready) i++;
        phase = 1'b1;
      end
    end
    check("send_count", 256'(i), 256'(count));
    @(negedge clk);
    tb_if.valid = 1'b0;
    tb_if.data  = 32'd0;
  endtask

  // Entered at the negedge one cycle after the last B word was accepted
  task automatic tail(input bit poke);
    check("flush_wr_b", wr_b, 1'b1);
    check("flush_state", state, 3'd2);
    check("flush_ready", tb_if.ready, 1'b0);
    check("flush_own", mem_own, 1'b1);
    @(negedge clk);
    check("start_pulse", mat_start, 1'b1);
    check("start_st", state, 3'd3);
    check("start_own_low", mem_own, 1'b0);
    check("start_wr_b", wr_b, 1'b0);
    @(negedge clk);
    check("wait_start_low", mat_start, 1'b0);
    check("wait_state", state, 3'd4);
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      load_start = (poke && c == 5) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    load_start = 1'b0;
    check("wait_hold", state, 3'd4);
    mat_done = 1'b1;
    @(negedge clk);
    mat_done = 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_state", state, 3'd5);
    @(negedge clk);
    check("done_low", done, 1'b0);
    check("back_idle", state, 3'd7);
    check("start_count", 256'(n_start), 256'd1);
  endtask

  task automatic check_mem(input int base);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("mem_a[%0d]", 8 + r), mem_a[8 + r], exp_row(base + 8*r));
      check($sformatf("mem_b[%0d]", r), mem_b[r], exp_row(base + 64 + 8*r));
    end
    check("wr_pulses", 256'(n_wr), 256'd16);
    check("wr_overlap", 256'(n_both), 256'd0);
    check("wr_timing", 256'(n_bad), 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, tb_if.ready, 1'b0);
    check({tag, "_wr"}, {wr_a, wr_b}, 2'b00);
    check({tag, "_addr"}, {addr_a, addr_b}, 8'h00);
    check({tag, "_wd"}, wd_a | wd_b, 256'd0);
    check({tag, "_flags"}, {mem_own, mat_start, done}, 3'b000);
    check({tag, "_state"}, state, 3'd7);
  endtask

  initial begin
    rstn = 1'b0; load_start = 1'b0; mat_done = 1'b0; clr = 1'b1;
    tb_if.valid = 1'b0; tb_if.data = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    clr  = 1'b0;

    // Back-to-back full load 1..128
    clear_model();
    kick();
    send(1, 128, 1'b0);
    tail(1'b0);
    check_mem(1);

    // valid toggling every cycle
    clear_model();
    kick();
    send(1, 128, 1'b1);
    tail(1'b0);
    check_mem(1);

    // load_start during LOAD_B and during WAIT is ignored
    clear_model();
    kick();
    send(1, 74, 1'b0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("poke_load_b", state, 3'd1);
    send(75, 54, 1'b0);
    tail(1'b1);
    check_mem(1);

    // Reset after 37 words, then a clean reload
    clear_model();
    kick();
    send(1, 37, 1'b0);
    rstn = 1'b0; clr = 1'b1;
    tb_if.valid = 1'b1; tb_if.data = 32'hDEAD_BEEF;
    #1;
    check_reset_outputs("abort");
    @(negedge clk); clr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    check("abort_no_wr", 256'(n_wr), 256'd0);
    tb_if.valid = 1'b0; tb_if.data = 32'd0;
    rstn = 1'b1;
    clear_model();
    kick();
    send(301, 128, 1'b0);
    tail(1'b0);
    check_mem(301);

    // Stray engine done in IDLE and LOAD_A
    clear_model();
    mat_done = 1'b1;
    @(negedge clk); mat_done = 1'b0;
    check("stray_idle", state, 3'd7);
    kick();
    send(501, 10, 1'b0);
    mat_done = 1'b1;
    @(negedge clk); mat_done = 1'b0;
    check("stray_load_a", state, 3'd0);
    send(511, 118, 1'b0);
    tail(1'b0);
    check_mem(501);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mat_stream_loader.md
Name: mat_stream_loader

Overview:
- Upstream feeder for the matrix-multiply engine.
- Accepts a 32-bit word stream over a valid/ready handshake and packs it into N-element rows.
- Writes 8 rows of A into memory A at A_ADDR_OFFSET and 8 rows of B into memory B at B_ADDR_OFFSET, then pulses start to the engine and waits for its done.
- o_mem_own tells the top-level mux that this block owns both memory ports.

Parameters:
DATA_LEN, 32, element width in bits
N, 8, elements per row (row word = DATA_LEN*N bits)
M, 8, rows per matrix
ADDRESS_SIZE, 4, memory address width
A_ADDR_OFFSET, 8, base address of matrix A rows in memory A
B_ADDR_OFFSET, 0, base address of matrix B rows in memory B

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_load_start  in  1  single-cycle request to begin a load
i_valid  in  1  stream word valid
i_data  in  DATA_LEN  stream word; row-major, all of A then all of B
o_ready  out  1  block accepts i_data this cycle
o_addr_A  out  ADDRESS_SIZE  memory A write address
o_wr_en_A  out  1  memory A write enable
o_write_data_A  out  DATA_LEN*N  memory A row data
o_addr_B  out  ADDRESS_SIZE  memory B write address
o_wr_en_B  out  1  memory B write enable
o_write_data_B  out  DATA_LEN*N  memory B row data
o_mem_own  out  1  loader owns memory ports
o_mat_start  out  1  one-cycle start pulse to the engine
i_mat_done  in  1  engine done pulse
o_done  out  1  one-cycle completion pulse
o_state  out  3  current state

Behaviour:
- Reset: i_rstn is asynchronous and active-low; the clock is i_clk. All registers clear: state=IDLE, counters=0, every output 0, data registers 0.
- Reset mid-operation aborts immediately; no further writes are issued.
- States:
  - IDLE=3'd7
  - LOAD_A=3'd0
  - LOAD_B=3'd1
  - FLUSH=3'd2
  - START=3'd3
  - WAIT=3'd4
  - DONE=3'd5
- IDLE: i_load_start moves to LOAD_A. i_load_start in any other state is ignored.
- LOAD_A / LOAD_B:
  - o_ready=1 combinationally.
  - A word is accepted when i_valid && o_ready.
  - The accepted word goes into pack buffer bits [DATA_LEN*col +: DATA_LEN], so element 0 sits in the LSBs.
  - col increments per accepted word and wraps N-1 to 0. row increments on col wrap.
- Row write:
  - On the cycle the word with col==N-1 is accepted (cycle t), the completed row (buffer with that word merged) is registered into o_write_data_X.
  - In cycle t+1: o_wr_en_X=1 for exactly one cycle, o_addr_X = OFFSET_X + row (truncated to ADDRESS_SIZE).
  - o_ready stays 1 during the write cycle; back-to-back rows at full rate are supported.
- Transitions:
  - Last A word (row==M-1, col==N-1) accepted: LOAD_B, with row and col reset to 0.
  - Last B word accepted: FLUSH.
  - FLUSH: o_wr_en_B=1 for the final B row, o_ready=0. Next state START.
  - START: o_mat_start=1 for one cycle. Next state WAIT.
  - WAIT: hold until i_mat_done=1, then DONE.
  - DONE: o_done=1 for one cycle. Next state IDLE.
- Handshake and ownership:
  - o_ready=0 in IDLE, FLUSH, START, WAIT and DONE.
  - i_data is ignored whenever o_ready=0.
  - o_mem_own=1 in LOAD_A, LOAD_B and FLUSH only.
- Write enables:
  - o_wr_en_A and o_wr_en_B are never high together.
  - The A-row-7 write occurs in the first LOAD_B cycle; a B word accepted in that same cycle is legal.
- Data path: data passes through unaltered, with no arithmetic. The buffer is not cleared between rows; each row is fully overwritten.
- i_valid gaps: counters and data hold; there is no timeout.
- Stray i_mat_done outside WAIT is ignored.
- Latency: the last B word accepted at cycle t gives wr_en_B at t+1, o_mat_start at t+2, and WAIT at t+3.

Test Plan:
- Reset, then 128 back-to-back words with values 1..128:
  - memory A addr 8..15 receives row r holding elements 8r+1..8r+8, element 0 in the LSBs;
  - memory B addr 0..7 holds 65..128;
  - exactly 16 write pulses.
- Same stream with i_valid toggling 1/0 every cycle: identical memory contents; wr_en pulses occur only after every 8th accepted word.
- Last B word accepted at cycle t:
  - o_wr_en_B high at t+1;
  - o_mat_start high at t+2 only;
  - o_mem_own low from t+2;
  - i_mat_done pulsed at t+10 gives o_done at t+11, then IDLE.
- i_load_start pulsed during LOAD_B and during WAIT: no state change; no extra write cycles.
- i_rstn asserted after 37 words: all outputs 0 within the reset. A fresh i_load_start plus 128 words produces correct contents with no residue from the aborted load.
- i_mat_done pulsed in IDLE and in LOAD_A: ignored. A subsequent full load completes normally.
